// File: rtl/x_dsm_quant.sv
// First-order delta-sigma quantiser: holds each PCM sample for OSR clocks and emits a B-bit code per clock.
// Latency: sample accepted at edge t -> active at t+1 -> first code registered at t+2.
// Backpressure: single-entry buffer, o_ready = !buf_valid; the buffer drains only at an OSR boundary.
module x_dsm_quant #(
    parameter int N   = 64,
    parameter int W   = 16,
    parameter int OSR = 32
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_valid,
    input  logic [W-1:0]         i_sample,
    output logic                 o_ready,
    output logic [$clog2(N)-1:0] o_bin,
    output logic                 o_underrun,
    output logic                 o_running
);

    localparam int B  = $clog2(N);
    localparam int F  = W - B;
    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
    localparam logic [B:0]    Q_MAX    = (B + 1)'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q;
    logic [W-1:0]   buf_q;
    logic           buf_vld_q;
    logic [W-1:0]   active_q;
    logic [F-1:0]   err_q;
    logic [CW-1:0]  cnt_q;
    logic [B-1:0]   bin_q;
    logic           underrun_q;

    logic [W:0]     sum;
    logic [B:0]     q;
    logic [B-1:0]   code_d;
    logic [F-1:0]   err_d;

    // Overflow past the top element saturates the error so the output stays pinned at N-1.
    always_comb begin
        sum    = {1'b0, active_q} + {{(B + 1){1'b0}}, err_q};
        q      = sum[W:F];
        code_d = q[B-1:0];
        err_d  = sum[F-1:0];
        if (q > Q_MAX) begin
            code_d = B'(N - 1);
            err_d  = '1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            active_q   <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
            bin_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (i_valid && !buf_vld_q) begin
                buf_q     <= i_sample;
                buf_vld_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    err_q <= '0;
                    bin_q <= '0;
                    if (buf_vld_q) begin
                        active_q  <= buf_q;
                        buf_vld_q <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    bin_q <= code_d;
                    err_q <= err_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (buf_vld_q) begin
                            active_q  <= buf_q;
                            buf_vld_q <= 1'b0;
                        end else begin
                            underrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready    = !buf_vld_q;
    assign o_bin      = bin_q;
    assign o_underrun = underrun_q;
    assign o_running  = (state_q == RUN);

endmodule
